reg_file_operand_rd: RTL and testbench

- Register bank that receives write-back data from the ALU/immediate selection stage.
- Returns operand pairs to the ALU through a registered valid/ready read port.
- It is the consuming (read) end of the write-back path: it stores what the selector produces and reads it back out as ALU operands.
- Provides write-to-read forwarding, plus a snapshot output register that holds steady under downstream stall.

---
 rtl/reg_file_operand_rd_if.sv | 29 ++
 rtl/reg_file_operand_rd.sv | 119 +++++++++++
 tb/tb_reg_file_operand_rd.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reg_file_operand_rd_if.sv
// Write-back and operand-read bundle between the write-back/ALU side and the
// operand register bank.
interface reg_file_operand_rd_if #(
    parameter  int bits  = 8,
    parameter  int NREGS = 8,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
);
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [bits-1:0] wr_data;
    logic            rd_req;
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic            rd_gnt;
    logic            op_ready;
    logic            op_valid;
    logic [bits-1:0] op_a;
    logic [bits-1:0] op_b;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, op_ready,
        input  rd_gnt, op_valid, op_a, op_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, op_ready,
        output rd_gnt, op_valid, op_a, op_b
    );
endinterface

// File: rtl/reg_file_operand_rd.sv
// Operand register bank: stores write-back data and presents operand pairs
// through a registered valid/ready port with write-to-read forwarding.
module reg_file_operand_rd #(
    parameter  int bits  = 8,
    parameter  int NREGS = 8,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_file_operand_rd_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [bits-1:0] bank_q [NREGS];
    logic [bits-1:0] bank_d [NREGS];
    logic [bits-1:0] op_a_q, op_a_d;
    logic [bits-1:0] op_b_q, op_b_d;
    logic [bits-1:0] cap_a_s, cap_b_s;
    logic            gnt_s;

    // A same-cycle write to the source register wins over the stale bank value.
    function automatic logic [bits-1:0] fwd_sel(
        input logic [AW-1:0]   src,
        input logic            we,
        input logic [AW-1:0]   wa,
        input logic [bits-1:0] wd,
        input logic [bits-1:0] stored
    );
        if (we && (src == wa)) begin
            return wd;
        end else begin
            return stored;
        end
    endfunction

    // Next bank contents: writes are never blocked by the output stall.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            bank_d[i] = (bus.wr_en && (bus.wr_addr == AW'(i))) ? bus.wr_data : bank_q[i];
        end
    end

    // Candidate operand values for a pair accepted this cycle.
    always_comb begin
        cap_a_s = fwd_sel(bus.rd_addr_a, bus.wr_en, bus.wr_addr, bus.wr_data, bank_q[bus.rd_addr_a]);
        cap_b_s = fwd_sel(bus.rd_addr_b, bus.wr_en, bus.wr_addr, bus.wr_data, bank_q[bus.rd_addr_b]);
    end

    // Output handshake: acceptance, next state and operand capture.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        gnt_s   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (bus.rd_req) begin
                    gnt_s   = 1'b1;
                    state_d = ST_LOADED;
                    op_a_d  = cap_a_s;
                    op_b_d  = cap_b_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_LOADED: begin
                if (bus.op_ready && bus.rd_req) begin
                    gnt_s   = 1'b1;
                    state_d = ST_LOADED;
                    op_a_d  = cap_a_s;
                    op_b_d  = cap_b_s;
                end else if (bus.op_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    // Stalled: the snapshot stays put even if its source is rewritten.
                    state_d = ST_LOADED;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Register bank storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_q[i] <= {bits{1'b0}};
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    // Output state and operand snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            op_a_q  <= {bits{1'b0}};
            op_b_q  <= {bits{1'b0}};
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign bus.rd_gnt   = gnt_s;
    assign bus.op_valid = (state_q == ST_LOADED);
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;

endmodule

// File: tb/tb_reg_file_operand_rd.sv
// Self-checking bench for reg_file_operand_rd: directed scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_reg_file_operand_rd;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference model state
    logic [7:0] m_bank [8];
    logic       m_valid;
    logic [7:0] m_a;
    logic [7:0] m_b;

    reg_file_operand_rd_if #(.bits(8), .NREGS(8)) bus ();

    reg_file_operand_rd #(.bits(8), .NREGS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
        m_valid = 1'b0;
        m_a     = 8'h00;
        m_b     = 8'h00;
    endtask

    // One clock cycle: drive, check grant, clock, update model, check outputs.
    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic rq, input logic [2:0] ra, input logic [2:0] rb,
                        input logic rdy);
        logic       eg;
        logic [7:0] na;
        logic [7:0] nb;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.rd_req    = rq;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        bus.op_ready  = rdy;
        #1;
        eg = rq & (~m_valid | rdy);
        check_val("rd_gnt", {31'd0, bus.rd_gnt}, {31'd0, eg});
        na = (we && wa == ra) ? wd : m_bank[ra];
        nb = (we && wa == rb) ? wd : m_bank[rb];
        @(posedge clk);
        if (eg) begin
            m_valid = 1'b1;
            m_a     = na;
            m_b     = nb;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (we) m_bank[wa] = wd;
        #1;
        check_val("op_valid", {31'd0, bus.op_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check_val("op_a", {24'd0, bus.op_a}, {24'd0, m_a});
            check_val("op_b", {24'd0, bus.op_b}, {24'd0, m_b});
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 3'd0;
        bus.wr_data   = 8'h00;
        bus.rd_req    = 1'b0;
        bus.rd_addr_a = 3'd0;
        bus.rd_addr_b = 3'd0;
        bus.op_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_op_valid", {31'd0, bus.op_valid}, 32'd0);
        check_val("reset_op_a", {24'd0, bus.op_a}, 32'd0);
        check_val("reset_op_b", {24'd0, bus.op_b}, 32'd0);
        rst_n = 1'b1;

        // Basic write then read
        step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd5, 8'hC3, 1'b0, 3'd0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd5, 1'b1);
        check_val("tp1_op_a", {24'd0, bus.op_a}, 32'h5A);
        check_val("tp1_op_b", {24'd0, bus.op_b}, 32'hC3);

        // Forwarding on both sources
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 1'b1);
        check_val("tp2_old_a", {24'd0, bus.op_a}, 32'h00);
        step(1'b1, 3'd2, 8'h7E, 1'b1, 3'd2, 3'd2, 1'b1);
        check_val("tp2_fwd_a", {24'd0, bus.op_a}, 32'h7E);
        check_val("tp2_fwd_b", {24'd0, bus.op_b}, 32'h7E);

        // Stall with a write to a captured register
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd5, 1'b1);
        step(1'b1, 3'd3, 8'h11, 1'b1, 3'd3, 3'd5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd5, 1'b0);
        check_val("tp3_hold_a", {24'd0, bus.op_a}, 32'h5A);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd5, 1'b1);
        check_val("tp3_new_a", {24'd0, bus.op_a}, 32'h11);

        // Back-to-back reads after loading rN = N+1
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(i + 1), 1'b0, 3'd0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'd0, 8'h00, 1'b1, 3'(2 * i), 3'(2 * i + 1), 1'b1);
            check_val("tp4_b2b_a", {24'd0, bus.op_a}, 32'(2 * i + 1));
            check_val("tp4_b2b_b", {24'd0, bus.op_b}, 32'(2 * i + 2));
        end

        // Drain
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1);
        check_val("tp5_drain", {31'd0, bus.op_valid}, 32'd0);

        // Asynchronous reset while stalled
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd5, 1'b1);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("tp6_rst_valid", {31'd0, bus.op_valid}, 32'd0);
        check_val("tp6_rst_a", {24'd0, bus.op_a}, 32'd0);
        check_val("tp6_rst_b", {24'd0, bus.op_b}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3, 1'b1);
        check_val("tp6_r3_cleared", {24'd0, bus.op_a}, 32'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
